pkt_power_tagger: RTL

Packet-level filter stage that sits directly upstream of the bypass FIFO and drives its write port (data, valid, power, ready). It accepts multi-beat packets delimited by sop/eop, looks up the packet ID from the header beat in a drop mask, and forwards every beat with a per-beat power flag. Power=0 beats are written to the FIFO but are skipped on its read side. The stage is one registered valid/ready slice with full throughput; it also applies truncation protection and keeps error statistics.

---
 rtl/pkt_power_tagger_if.sv | 25 ++
 rtl/pkt_power_tagger.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pkt_power_tagger_if.sv
// Stream bundle between the upstream packet source, the power tagger and the
// bypass FIFO write port. The tagger uses the slave view.
interface pkt_power_tagger_if #(
  parameter int WIDTH = 128
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_sop;
  logic             in_eop;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_power;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_power
  );

  modport master (
    output in_valid, in_data, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_power
  );
endinterface

// File: rtl/pkt_power_tagger.sv
// Packet filter in front of the bypass FIFO: one registered valid/ready slice
// that tags each beat with a keep/skip power flag and counts drops and errors.
module pkt_power_tagger #(
  parameter int WIDTH     = 128,
  parameter int ID_WD     = 4,
  parameter int MAX_BEATS = 16,
  parameter int CNT_WD    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pkt_power_tagger_if.slave     bus,
  input  logic [2**ID_WD-1:0]   drop_mask,
  output logic [CNT_WD-1:0]     drop_cnt,
  output logic [CNT_WD-1:0]     err_cnt
);

  localparam int BC_WD = $clog2(MAX_BEATS + 2);
  localparam logic [BC_WD-1:0]  MAX_C    = BC_WD'(MAX_BEATS);
  localparam logic [BC_WD-1:0]  ONE_C    = BC_WD'(1'b1);
  localparam logic [BC_WD-1:0]  CAP_C    = MAX_C + ONE_C;
  localparam logic [CNT_WD-1:0] CNT_ONE  = CNT_WD'(1'b1);
  localparam logic [CNT_WD-1:0] CNT_MAX  = {CNT_WD{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PKT   = 2'd1,
    ST_TRUNC = 2'd2
  } state_t;

  state_t             r_state;
  logic [BC_WD-1:0]   r_beat_cnt;
  logic               r_pkt_pow;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_power;
  logic [CNT_WD-1:0]  r_drop_cnt;
  logic [CNT_WD-1:0]  r_err_cnt;

  logic               w_in_ready;
  logic               w_in_hs;
  logic               w_lookup_pow;
  logic [BC_WD-1:0]   w_cnt_inc;
  logic               w_over;
  logic               w_tag;
  logic               w_err_inc;
  logic               w_drop_inc;
  state_t             w_state_nxt;
  logic [BC_WD-1:0]   w_cnt_nxt;
  logic               w_pow_nxt;

  function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] v,
                                                input logic en);
    if (en && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end else begin
      return v;
    end
  endfunction

  // Ready depends only on the slice occupancy and out_ready, never on in_valid.
  assign w_in_ready   = ~r_out_valid | bus.out_ready;
  assign w_in_hs      = bus.in_valid & w_in_ready;
  assign w_lookup_pow = ~drop_mask[bus.in_data[ID_WD-1:0]];
  assign w_cnt_inc    = (r_beat_cnt >= CAP_C) ? CAP_C : (r_beat_cnt + ONE_C);
  assign w_over       = (w_cnt_inc > MAX_C);

  // Per-beat decode: power tag, counter events and next packet state.
  always_comb begin
    w_tag       = 1'b0;
    w_err_inc   = 1'b0;
    w_drop_inc  = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_beat_cnt;
    w_pow_nxt   = r_pkt_pow;
    if (w_in_hs) begin
      if (bus.in_sop) begin
        // Any sop restarts a packet; outside IDLE the previous one lacked eop.
        w_pow_nxt   = w_lookup_pow;
        w_cnt_nxt   = ONE_C;
        w_tag       = w_lookup_pow;
        w_drop_inc  = ~w_lookup_pow;
        w_err_inc   = (r_state != ST_IDLE);
        w_state_nxt = bus.in_eop ? ST_IDLE : ST_PKT;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_err_inc = 1'b1;
          end
          ST_PKT: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_over) begin
              w_err_inc   = 1'b1;
              w_state_nxt = bus.in_eop ? ST_IDLE : ST_TRUNC;
            end else begin
              w_tag       = r_pkt_pow;
              w_state_nxt = bus.in_eop ? ST_IDLE : ST_PKT;
            end
          end
          ST_TRUNC: begin
            w_state_nxt = bus.in_eop ? ST_IDLE : ST_TRUNC;
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
    end else begin
      w_tag = 1'b0;
    end
  end

  // Packet FSM and per-packet context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_pkt_pow  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_pkt_pow  <= w_pow_nxt;
    end
  end

  // Output slice: loads on input handshake, empties when drained without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_power <= 1'b0;
    end else if (w_in_hs) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data;
      r_out_power <= w_tag;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_drop_cnt <= sat_inc(r_drop_cnt, w_drop_inc);
      r_err_cnt  <= sat_inc(r_err_cnt, w_err_inc);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_power = r_out_power;
  assign drop_cnt      = r_drop_cnt;
  assign err_cnt       = r_err_cnt;

endmodule
